// File: rtl/axi4_wr_ctl_if.sv
// AXI4 bus bundle shared by the write controller and its interconnect.
// The master modport drives AW/W/AR plus BREADY/RREADY; the rest flows back.
interface axi4_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 1
);
    localparam int SW = DW / 8;

    logic [IW-1:0] AWID;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWLOCK;
    logic [3:0]    AWCACHE;
    logic [2:0]    AWPROT;
    logic [3:0]    AWQOS;
    logic [3:0]    AWREGION;
    logic          AWVALID;
    logic          AWREADY;

    logic [IW-1:0] WID;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;

    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;

    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARLOCK;
    logic [3:0]    ARCACHE;
    logic [2:0]    ARPROT;
    logic [3:0]    ARQOS;
    logic [3:0]    ARREGION;
    logic          ARVALID;
    logic          ARREADY;

    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    modport m (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
               ARQOS, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi4_wr_ctl.sv
// Single-burst AXI4 write controller: takes (address, length) plus a data
// stream, issues one INCR burst, and reports BRESP on a one-cycle status strobe.
module axi4_wr_ctl #(
    parameter int            AW = 32,
    parameter int            DW = 32,
    parameter int            SW = DW / 8,
    parameter int            IW = 1,
    parameter int            LW = 8,
    parameter logic [IW-1:0] ID = '0
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic [AW-1:0] cmd_adr,
    input  logic [LW-1:0] cmd_len,
    input  logic          dat_vld,
    output logic          dat_rdy,
    input  logic [DW-1:0] dat_dat,
    input  logic [SW-1:0] dat_sel,
    output logic          sts_vld,
    output logic [1:0]    sts_rsp,
    output logic          busy,
    axi4_if.m             axi
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [2:0] SIZE = 3'($clog2(SW));

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          sts_vld_q, sts_vld_d;
    logic [1:0]    sts_rsp_q, sts_rsp_d;

    logic in_burst;
    logic aw_vld;
    logic w_vld;
    logic w_last;
    logic aw_hs;
    logic w_hs;

    assign in_burst = (state_q == BURST);
    assign aw_vld   = in_burst & ~aw_done_q;
    assign w_vld    = in_burst & dat_vld & ~w_done_q;
    assign w_last   = (cnt_q == len_q);
    assign aw_hs    = aw_vld & axi.AWREADY;
    assign w_hs     = w_vld & axi.WREADY;

    assign cmd_rdy = (state_q == IDLE);
    assign dat_rdy = in_burst & axi.WREADY & ~w_done_q;
    assign busy    = (state_q != IDLE);
    assign sts_vld = sts_vld_q;
    assign sts_rsp = sts_rsp_q;

    assign axi.AWID     = ID;
    assign axi.AWADDR   = adr_q;
    assign axi.AWLEN    = 8'(len_q);
    assign axi.AWSIZE   = SIZE;
    assign axi.AWBURST  = 2'b01;
    assign axi.AWLOCK   = 1'b0;
    assign axi.AWCACHE  = 4'b0011;
    assign axi.AWPROT   = 3'b000;
    assign axi.AWQOS    = 4'b0000;
    assign axi.AWREGION = 4'b0000;
    assign axi.AWVALID  = aw_vld;

    assign axi.WID    = ID;
    assign axi.WDATA  = dat_dat;
    assign axi.WSTRB  = dat_sel;
    assign axi.WLAST  = w_last;
    assign axi.WVALID = w_vld;

    assign axi.BREADY = (state_q == RESP);

    assign axi.ARID     = '0;
    assign axi.ARADDR   = '0;
    assign axi.ARLEN    = '0;
    assign axi.ARSIZE   = '0;
    assign axi.ARBURST  = '0;
    assign axi.ARLOCK   = 1'b0;
    assign axi.ARCACHE  = '0;
    assign axi.ARPROT   = '0;
    assign axi.ARQOS    = '0;
    assign axi.ARREGION = '0;
    assign axi.ARVALID  = 1'b0;
    assign axi.RREADY   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{axi.BID, axi.ARREADY, axi.RID, axi.RDATA, axi.RRESP,
                         axi.RLAST, axi.RVALID};

    // The counter holds on the last beat, so a full 2^LW-beat burst never wraps.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        sts_vld_d = 1'b0;
        sts_rsp_d = sts_rsp_q;
        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    adr_d     = cmd_adr;
                    len_d     = cmd_len;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (w_last) begin
                        w_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi.BVALID) begin
                    sts_vld_d = 1'b1;
                    sts_rsp_d = axi.BRESP;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            sts_vld_q <= 1'b0;
            sts_rsp_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            sts_vld_q <= sts_vld_d;
            sts_rsp_q <= sts_rsp_d;
        end
    end

endmodule

// File: tb/tb_axi4_wr_ctl.sv
// Bench for axi4_wr_ctl: acts as client and AXI slave, and predicts every
// handshake from the burst arguments and the cycles at which beats complete.
module tb_axi4_wr_ctl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic        dat_vld;
    logic        dat_rdy;
    logic [31:0] dat_dat;
    logic [3:0]  dat_sel;
    logic        sts_vld;
    logic [1:0]  sts_rsp;
    logic        busy;

    logic [31:0] dataMem [256];
    logic [3:0]  selMem  [256];

    int assertCount = 0;
    int failCount   = 0;

    axi4_if #(.AW(32), .DW(32), .IW(1)) axi ();

    axi4_wr_ctl dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .cmd_adr (cmd_adr),
        .cmd_len (cmd_len),
        .dat_vld (dat_vld),
        .dat_rdy (dat_rdy),
        .dat_dat (dat_dat),
        .dat_sel (dat_sel),
        .sts_vld (sts_vld),
        .sts_rsp (sts_rsp),
        .busy    (busy),
        .axi     (axi)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) begin
            dataMem[i] = $urandom;
            selMem[i]  = 4'($urandom);
        end
    endtask

    task automatic idleInputs();
        cmd_vld     = 1'b0;
        cmd_adr     = '0;
        cmd_len     = '0;
        dat_vld     = 1'b0;
        dat_dat     = '0;
        dat_sel     = '0;
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        axi.BID     = '0;
        axi.ARREADY = 1'b0;
        axi.RID     = '0;
        axi.RDATA   = '0;
        axi.RRESP   = '0;
        axi.RLAST   = 1'b0;
        axi.RVALID  = 1'b0;
    endtask

    // One burst: AW ready after awDelay cycles, optional random W stalls, B after
    // bDelay cycles once both address and all data have been accepted.
    // abortAfter >= 0 drops ARESETn once that many beats have gone through.
    task automatic applyStimulus(input logic [31:0] adr, input int len, input int awDelay,
                                 input bit stall, input int bDelay, input logic [1:0] resp,
                                 input bit spam, input int abortAfter);
        int beats    = 0;
        bit awDone   = 1'b0;
        bit bothDone = 1'b0;
        bit bDone    = 1'b0;
        int doneCyc  = 0;
        @(negedge ACLK);
        cmd_vld = 1'b1;
        cmd_adr = adr;
        cmd_len = 8'(len);
        #1;
        checkOutput("cmdRdyIdle", cmd_rdy, 1);
        checkOutput("busyIdle", busy, 0);
        for (int cyc = 1; cyc <= 3000 && !bDone; cyc++) begin
            @(negedge ACLK);
            cmd_vld     = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_adr     = $urandom;
            cmd_len     = 8'($urandom);
            axi.AWREADY = (cyc > awDelay);
            if (beats <= len) begin
                dat_vld = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                dat_dat = dataMem[beats];
                dat_sel = selMem[beats];
            end else begin
                dat_vld = 1'b1;
                dat_dat = $urandom;
                dat_sel = 4'($urandom);
            end
            axi.WREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.BVALID = bothDone && (cyc >= doneCyc + 1 + bDelay);
            axi.BRESP  = axi.BVALID ? resp : 2'($urandom);
            if (abortAfter >= 0 && beats == abortAfter) begin
                dat_vld    = 1'b1;
                axi.WREADY = 1'b1;
                #1;
                checkOutput("preRstAwvalid", axi.AWVALID, 1);
                checkOutput("preRstWvalid", axi.WVALID, 1);
                #1 ARESETn = 1'b0;
                #1;
                checkOutput("rstAwvalid", axi.AWVALID, 0);
                checkOutput("rstWvalid", axi.WVALID, 0);
                checkOutput("rstBready", axi.BREADY, 0);
                checkOutput("rstDatRdy", dat_rdy, 0);
                checkOutput("rstBusy", busy, 0);
                cmd_vld = 1'b0;
                return;
            end
            #1;
            checkOutput("cmdRdyBusy", cmd_rdy, 0);
            checkOutput("busyBurst", busy, 1);
            checkOutput("awvalid", axi.AWVALID, !awDone);
            checkOutput("wvalid", axi.WVALID, dat_vld && (beats <= len));
            checkOutput("datRdy", dat_rdy, axi.WREADY && (beats <= len));
            checkOutput("bready", axi.BREADY, bothDone && (cyc > doneCyc));
            checkOutput("arvalid", axi.ARVALID, 0);
            checkOutput("stsQuiet", sts_vld, 0);
            if (!awDone) begin
                checkOutput("awaddr", axi.AWADDR, adr);
                checkOutput("awlen", axi.AWLEN, len);
                if (axi.AWREADY) begin
                    checkOutput("awsize", axi.AWSIZE, 2);
                    checkOutput("awburst", axi.AWBURST, 1);
                    checkOutput("awcache", axi.AWCACHE, 3);
                    checkOutput("awid", axi.AWID, 0);
                    checkOutput("awlockProt", {axi.AWLOCK, axi.AWPROT, axi.AWQOS, axi.AWREGION}, 0);
                    awDone = 1'b1;
                end
            end
            if (dat_vld && axi.WREADY && beats <= len) begin
                checkOutput("wdata", axi.WDATA, dataMem[beats]);
                checkOutput("wstrb", axi.WSTRB, selMem[beats]);
                checkOutput("wlast", axi.WLAST, beats == len);
                checkOutput("wid", axi.WID, 0);
                beats++;
            end
            if (!bothDone && awDone && beats > len) begin
                bothDone = 1'b1;
                doneCyc  = cyc;
            end
            if (axi.BVALID && bothDone && cyc > doneCyc) begin
                bDone = 1'b1;
            end
        end
        checkOutput("burstTimeout", bDone, 1);
        checkOutput("beatCount", beats, len + 1);
        @(negedge ACLK);
        cmd_vld    = 1'b0;
        dat_vld    = 1'b0;
        axi.BVALID = 1'b0;
        #1;
        checkOutput("stsVld", sts_vld, 1);
        checkOutput("stsRsp", sts_rsp, resp);
        checkOutput("cmdRdyBack", cmd_rdy, 1);
        checkOutput("busyBack", busy, 0);
        checkOutput("breadyBack", axi.BREADY, 0);
        @(negedge ACLK);
        #1;
        checkOutput("stsPulse", sts_vld, 0);
        checkOutput("stsRspHold", sts_rsp, resp);
    endtask

    initial begin
        ARESETn = 1'b0;
        idleInputs();
        repeat (3) @(negedge ACLK);
        #1;
        $display("[TB] checking reset state");
        checkOutput("resetAwvalid", axi.AWVALID, 0);
        checkOutput("resetWvalid", axi.WVALID, 0);
        checkOutput("resetBready", axi.BREADY, 0);
        checkOutput("resetDatRdy", dat_rdy, 0);
        checkOutput("resetSts", {sts_vld, sts_rsp}, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetAddrLen", {axi.AWADDR, axi.AWLEN}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checkOutput("releaseCmdRdy", cmd_rdy, 1);

        $display("[TB] single beat");
        dataMem[0] = 32'hA5A5A5A5;
        selMem[0]  = 4'hF;
        applyStimulus(32'h100, 0, 0, 1'b0, 0, 2'b00, 1'b0, -1);

        $display("[TB] four beats, late AWREADY");
        for (int k = 0; k < 4; k++) begin
            dataMem[k] = 32'(k + 1);
            selMem[k]  = 4'hF;
        end
        applyStimulus(32'h1000, 3, 5, 1'b0, 0, 2'b00, 1'b0, -1);

        $display("[TB] eight beats with stalls");
        fillRandom();
        applyStimulus($urandom, 7, 2, 1'b1, 2, 2'b00, 1'b0, -1);

        $display("[TB] SLVERR with ignored commands");
        fillRandom();
        applyStimulus(32'h2000, 3, 1, 1'b0, 3, 2'b10, 1'b1, -1);

        $display("[TB] maximum length");
        fillRandom();
        applyStimulus(32'h3000, 255, 40, 1'b1, 1, 2'b00, 1'b0, -1);

        $display("[TB] reset mid-burst");
        fillRandom();
        applyStimulus(32'h4000, 3, 20, 1'b0, 0, 2'b00, 1'b0, 2);
        repeat (2) @(negedge ACLK);
        idleInputs();
        ARESETn = 1'b1;
        #1;
        checkOutput("postRstBusy", busy, 0);
        checkOutput("postRstCmdRdy", cmd_rdy, 1);
        checkOutput("postRstSts", sts_vld, 0);
        fillRandom();
        applyStimulus(32'h200, 1, 0, 1'b0, 0, 2'b00, 1'b0, -1);

        $display("[TB] random bursts");
        for (int n = 0; n < 4; n++) begin
            fillRandom();
            applyStimulus($urandom, $urandom_range(0, 15), $urandom_range(0, 6), 1'b1,
                          $urandom_range(0, 3), 2'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/axi4_wr_ctl.md
Name: axi4_wr_ctl

Overview:
Write-burst controller that sequences the AW, W and B channels of an AXI4 master port from a simple command and data stream. A client issues (address, length) on the command port and streams data beats. The block issues one INCR burst, counts beats, generates WLAST, collects the write response and reports it on a status strobe. It sits between local DMA/SPI data engines and the system AXI4 interconnect. The read channels are tied off.

Parameters:
AW, 32, address width (matches axi4_if AW)
DW, 32, data width (matches axi4_if DW)
SW, DW/8, byte-strobe width
IW, 1, ID width
LW, 8, burst length width
ID, 0, constant transaction ID driven on AWID/WID

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
cmd_vld  input  1  command valid
cmd_rdy  output  1  command ready
cmd_adr  input  AW  burst start address, byte address
cmd_len  input  LW  burst length in beats minus 1
dat_vld  input  1  data beat valid
dat_rdy  output  1  data beat ready
dat_dat  input  DW  write data
dat_sel  input  SW  byte strobes
sts_vld  output  1  one-cycle pulse: burst completed
sts_rsp  output  2  BRESP of the completed burst
busy  output  1  burst in progress (state != IDLE)
axi  modport  axi4_if.m  AXI4 master port

Behaviour:
- One clock, ACLK. ARESETn is asynchronous and active-low; it is asserted asynchronously and released synchronously by the system reset block.
- FSM states: IDLE, BURST, RESP.
- IDLE: cmd_rdy=1.
  - cmd_vld&cmd_rdy registers adr_q<=cmd_adr and len_q<=cmd_len.
  - It clears beat counter cnt<=0, aw_done<=0 and w_done<=0, then goes to BURST.
- BURST:
  - AWVALID=~aw_done; AWADDR=adr_q; AWLEN=len_q.
  - AWVALID&AWREADY sets aw_done. Once asserted, AWVALID stays high until the handshake; AWADDR and AWLEN stay stable.
  - W path is independent of the AW handshake; data may precede, follow or coincide with the address.
  - WVALID=dat_vld&~w_done; dat_rdy=WREADY&~w_done (combinational).
  - WDATA=dat_dat; WSTRB=dat_sel; WID=ID.
  - WLAST=(cnt==len_q).
  - Each WVALID&WREADY increments cnt. The beat with WLAST sets w_done.
  - When aw_done and w_done are both set (the setting events may occur in the same cycle), go to RESP on the next clock.
- RESP:
  - BREADY=1.
  - On BVALID: sts_vld=1 for exactly one cycle (registered, the cycle after the handshake) and sts_rsp<=BRESP. Return to IDLE.
  - BID is not checked.
- sts_vld has no backpressure; the client must accept it.
- cmd_rdy is 0 in BURST and RESP. A new command is accepted at the earliest in the cycle after the return to IDLE.
- Fixed AW fields:
  - AWID=ID; AWSIZE=clog2(SW); AWBURST=2'b01 (INCR).
  - AWLOCK=0; AWCACHE=4'b0011; AWPROT=0; AWQOS=0; AWREGION=0.
- Read channels: ARVALID=0, RREADY=0, all AR fields 0.
- cnt is LW bits wide. With cmd_len=2^LW-1, cnt reaches the max value on the last beat and never wraps within a burst.
- The block does not check for 4KB boundary crossing or alignment; the client guarantees legal bursts.
- Reset values:
  - state=IDLE; cmd_rdy=1 after reset release.
  - AWVALID=0, WVALID=0, BREADY=0, dat_rdy=0.
  - sts_vld=0, sts_rsp=0, busy=0.
  - adr_q=0, len_q=0, cnt=0.
- Reset mid-burst: all valids drop immediately (asynchronous) and the FSM returns to IDLE. Any partial burst is abandoned; the interconnect shares ARESETn.
- Latency (all ready signals held high):
  - cmd handshake at cycle 0.
  - AW and first W beat at cycle 1.
  - Last W beat at cycle 1+len.
  - BREADY from cycle 2+len.
  - sts_vld one cycle after the B handshake.

Test Plan:
- Single beat: cmd_adr=0x100, cmd_len=0, dat_dat=0xA5A5A5A5, sel=0xF, all readies high -> AWADDR=0x100, AWLEN=0, AWSIZE=2, AWBURST=1. One W beat with WLAST=1. BVALID with OKAY -> sts_vld pulse with sts_rsp=0; cmd_rdy returns to 1.
- 4-beat, AWREADY delayed 5 cycles, data supplied immediately -> all 4 W beats (data 1..4) complete before AW. AWVALID is held stable until AWREADY. WLAST appears only on beat 4. RESP is entered only after aw_done.
- 8-beat with random WREADY and dat_vld stalls -> exactly 8 handshakes, data in order, WLAST only on the 8th. No WVALID after the last beat, even while dat_vld stays high.
- SLVERR: BRESP=2'b10 -> sts_rsp=2'b10 with a single-cycle sts_vld. Extra cmd_vld pulses during BURST/RESP are ignored (cmd_rdy=0).
- Max length: cmd_len=255 -> 256 beats, cnt does not wrap early, WLAST on beat 256.
- Reset mid-burst: assert ARESETn=0 after beat 2 of 4 -> AWVALID, WVALID and BREADY go to 0 without waiting for a clock. After release, busy=0 and cmd_rdy=1, and the next command (adr 0x200, len 1) completes normally.
